// File: rtl/encoder_8to3.sv
// Registered 8-to-3 priority encoder with valid and multi-hot flags.
// The winner is chosen from the highest or lowest set bit, selected by MSB_PRIORITY. Outputs are registered, so there is one cycle of latency.
module encoder_8to3 #(
    parameter bit MSB_PRIORITY = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [7:0] i_data,
    output logic [2:0] y,
    output logic       valid,
    output logic       multi
);

    logic [2:0] win;
    logic       any_set;
    logic       multi_set;
    logic [2:0] y_d, y_q;
    logic       valid_d, valid_q;
    logic       multi_d, multi_q;

    // The last match in scan order wins, so the scan direction sets the priority.
    always_comb begin
        win = 3'b000;
        if (MSB_PRIORITY) begin
            for (int k = 0; k < 8; k++) begin
                if (i_data[k]) win = 3'(k);
            end
        end else begin
            for (int k = 7; k >= 0; k--) begin
                if (i_data[k]) win = 3'(k);
            end
        end
    end

    assign any_set   = |i_data;
    assign multi_set = |(i_data & (i_data - 8'd1));

    always_comb begin
        y_d     = y_q;
        valid_d = valid_q;
        multi_d = multi_q;
        if (en) begin
            y_d     = any_set ? win : 3'b000;
            valid_d = any_set;
            multi_d = multi_set;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q     <= 3'b000;
            valid_q <= 1'b0;
            multi_q <= 1'b0;
        end else begin
            y_q     <= y_d;
            valid_q <= valid_d;
            multi_q <= multi_d;
        end
    end

    assign y     = y_q;
    assign valid = valid_q;
    assign multi = multi_q;

endmodule

// File: tb/tb_encoder_8to3.sv
// Self-checking bench for encoder_8to3.
// Both priority settings are instantiated side by side and checked against tables, directed sequences and a reference model.
module tb_encoder_8to3;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [7:0] i_data;
    logic [2:0] y_m, y_l;
    logic       valid_m, valid_l, multi_m, multi_l;

    int checks = 0;
    int errors = 0;

    logic [2:0] exp_ym, exp_yl;
    logic       exp_v, exp_mu;

    encoder_8to3 #(.MSB_PRIORITY(1'b1)) dut_msb (
        .clk(clk), .rst_n(rst_n), .en(en), .i_data(i_data),
        .y(y_m), .valid(valid_m), .multi(multi_m)
    );

    encoder_8to3 #(.MSB_PRIORITY(1'b0)) dut_lsb (
        .clk(clk), .rst_n(rst_n), .en(en), .i_data(i_data),
        .y(y_l), .valid(valid_l), .multi(multi_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic [2:0] y_msb;
        logic [2:0] y_lsb;
        logic       v;
        logic       m;
    } vec_t;

    // Highest set bit of x is floor(log2(x)), and x & -x isolates the lowest set bit.
    function automatic logic [2:0] ref_msb(input logic [7:0] x);
        int n = x;
        if (n == 0) return 3'd0;
        return 3'($clog2(n + 1) - 1);
    endfunction

    function automatic logic [2:0] ref_lsb(input logic [7:0] x);
        int n = x;
        int low;
        if (n == 0) return 3'd0;
        low = n & (-n);
        return 3'($clog2(low));
    endfunction

    task automatic check(input string name, input logic [4:0] got, input logic [4:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got {y,valid,multi}=%b expected %b at %0t", name, got, want, $time);
        end
    endtask

    task automatic check_both(input string name, input logic [2:0] ym, input logic [2:0] yl,
                              input logic v, input logic mu);
        check({name, "/msb"}, {y_m, valid_m, multi_m}, {ym, v, mu});
        check({name, "/lsb"}, {y_l, valid_l, multi_l}, {yl, v, mu});
    endtask

    // Drive inputs at the falling edge, let one rising edge pass, then update the model.
    task automatic step(input logic [7:0] d, input logic e);
        @(negedge clk);
        i_data = d;
        en     = e;
        @(posedge clk);
        if (e) begin
            exp_ym = ref_msb(d);
            exp_yl = ref_lsb(d);
            exp_v  = (d != 8'h00);
            exp_mu = ($countones(d) >= 2);
        end
        #1;
    endtask

    vec_t tbl[$];

    initial begin
        tbl.push_back('{8'h01, 3'd0, 3'd0, 1'b1, 1'b0});
        tbl.push_back('{8'h80, 3'd7, 3'd7, 1'b1, 1'b0});
        tbl.push_back('{8'h00, 3'd0, 3'd0, 1'b0, 1'b0});
        tbl.push_back('{8'h24, 3'd5, 3'd2, 1'b1, 1'b1});
        tbl.push_back('{8'hFF, 3'd7, 3'd0, 1'b1, 1'b1});
        tbl.push_back('{8'h81, 3'd7, 3'd0, 1'b1, 1'b1});
        tbl.push_back('{8'h18, 3'd4, 3'd3, 1'b1, 1'b1});
        tbl.push_back('{8'h40, 3'd6, 3'd6, 1'b1, 1'b0});

        exp_ym = 3'd0; exp_yl = 3'd0; exp_v = 1'b0; exp_mu = 1'b0;
        rst_n  = 1'b0;
        en     = 1'b1;
        i_data = 8'hFF;
        #2;
        check_both("reset_async", 3'd0, 3'd0, 1'b0, 1'b0);
        @(posedge clk); #1;
        check_both("reset_held", 3'd0, 3'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Hold each one-hot value for ten cycles; every sample after the change must show it.
        for (int k = 0; k < 8; k++) begin
            for (int c = 0; c < 10; c++) begin
                step(8'(1 << k), 1'b1);
                check_both($sformatf("onehot_%0d", k), 3'(k), 3'(k), 1'b1, 1'b0);
            end
        end

        foreach (tbl[i]) begin
            step(tbl[i].data, 1'b1);
            check_both($sformatf("table_%02h", tbl[i].data), tbl[i].y_msb, tbl[i].y_lsb, tbl[i].v, tbl[i].m);
        end

        step(8'h10, 1'b1);
        check_both("hold_capture", 3'd4, 3'd4, 1'b1, 1'b0);
        for (int c = 0; c < 5; c++) begin
            step(8'h02, 1'b0);
            check_both("hold_en0", 3'd4, 3'd4, 1'b1, 1'b0);
        end
        step(8'h02, 1'b1);
        check_both("hold_reenable", 3'd1, 3'd1, 1'b1, 1'b0);

        step(8'h01, 1'b1);
        check_both("latency_pre", 3'd0, 3'd0, 1'b1, 1'b0);
        i_data = 8'h80;
        @(negedge clk);
        check_both("latency_mid", 3'd0, 3'd0, 1'b1, 1'b0);
        @(posedge clk); #1;
        check_both("latency_post", 3'd7, 3'd7, 1'b1, 1'b0);

        step(8'h20, 1'b1);
        check_both("midreset_pre", 3'd5, 3'd5, 1'b1, 1'b0);
        @(negedge clk);
        i_data = 8'h81;
        #2 rst_n = 1'b0;
        #1;
        check_both("midreset_async", 3'd0, 3'd0, 1'b0, 1'b0);
        @(posedge clk); #1;
        check_both("midreset_held", 3'd0, 3'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_ym = 3'd0; exp_yl = 3'd0; exp_v = 1'b0; exp_mu = 1'b0;

        for (int r = 0; r < 300; r++) begin
            logic [7:0] d;
            logic       e;
            d = 8'($urandom);
            if ($urandom_range(0, 3) == 0) d = 8'(1 << $urandom_range(0, 7));
            if ($urandom_range(0, 15) == 0) d = 8'h00;
            e = ($urandom_range(0, 3) != 0);
            step(d, e);
            check_both("random", exp_ym, exp_yl, exp_v, exp_mu);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got time %0t required < 200000", $time);
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
